dds_table_reader: RTL and testbench

DDS_TABLE_READER -- requirements
Module: dds_table_reader

---
 rtl/dds_table_reader.sv | 126 ++++++++++++
 tb/tb_dds_table_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_table_reader.sv
// Direct digital synthesis table reader: a phase accumulator addresses a waveform
// table RAM, and the returned samples are re-registered and qualified by wave_valid.
module dds_table_reader #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int RAM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic                   freq_load,
    input  logic [PHASE_WIDTH-1:0] phase_offset,
    input  logic [15:0]            sample_count,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   ram_we,
    input  logic [DATA_WIDTH-1:0]  ram_rdata,
    output logic [DATA_WIDTH-1:0]  wave_out,
    output logic                   wave_valid,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                 state;
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] inc;
    logic [PHASE_WIDTH-1:0] off;
    logic [15:0]            remaining;
    logic                   continuous;
    logic [RAM_LATENCY-1:0] valid_pipe;
    logic [ADDR_WIDTH-1:0]  addr_hold;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   issue;
    logic                   pipe_empty;

    assign phase      = acc + off;
    assign issue      = (state == S_RUN) && !stop;
    assign pipe_empty = (valid_pipe == '0);

    // The address leaves in the issuing cycle itself, so RAM latency is counted from
    // there; between issues the last issued address is held.
    assign ram_addr = issue ? phase[PHASE_WIDTH-1 -: ADDR_WIDTH] : addr_hold;
    assign ram_we   = 1'b0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DRAIN) && pipe_empty;

    // Read-return path: valid marker travels alongside the RAM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe <= '0;
            addr_hold  <= '0;
            wave_out   <= '0;
            wave_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the previous-cycle
            // value of its neighbour, which is what makes this a shift register.
            valid_pipe[0] <= issue;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
            wave_valid <= valid_pipe[RAM_LATENCY-1];
            if (valid_pipe[RAM_LATENCY-1]) begin
                wave_out <= ram_rdata;
            end
            if (issue) begin
                addr_hold <= phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            inc        <= '0;
            off        <= '0;
            remaining  <= '0;
            continuous <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        acc        <= '0;
                        inc        <= freq_word;
                        off        <= phase_offset;
                        remaining  <= sample_count;
                        continuous <= (sample_count == 16'd0);
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_DRAIN;
                    end else begin
                        // A reloaded increment only affects the accumulation after this one.
                        acc <= acc + inc;
                        if (freq_load) begin
                            inc <= freq_word;
                        end
                        if (!continuous) begin
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_table_reader.sv
// Self-checking bench for dds_table_reader: identity table RAM with two-cycle read
// latency, vector table, hand-written corner sequences and randomized runs.
module tb_dds_table_reader;

    localparam int PW = 32;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [PW-1:0] freq_word;
    logic          freq_load;
    logic [PW-1:0] phase_offset;
    logic [15:0]   sample_count;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] wave_out;
    logic          wave_valid;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dds_table_reader #(
        .PHASE_WIDTH (PW),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RAM_LATENCY (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .freq_word    (freq_word),
        .freq_load    (freq_load),
        .phase_offset (phase_offset),
        .sample_count (sample_count),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata),
        .wave_out     (wave_out),
        .wave_valid   (wave_valid),
        .busy         (busy),
        .done         (done)
    );

    // Identity table RAM: address register then output register.
    logic [AW-1:0] ram_addr_r;
    always @(posedge clk) begin
        ram_addr_r <= ram_addr;
        ram_rdata  <= DW'(ram_addr_r);
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    int            done_n  = 0;
    int            done_at = 0;

    always @(negedge clk) begin
        if (wave_valid === 1'b1) begin
            got_q.push_back(wave_out);
            got_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_n++;
            done_at = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One generation run. Inputs are referenced to j, the cycle count after the start
    // cycle; stop_at == 0 asserts stop together with start.
    task automatic run_case(input string name, input logic [PW-1:0] fw, input logic [PW-1:0] po,
                            input logic [15:0] sc, input int stop_at, input int load_at,
                            input logic [PW-1:0] load_val, input int rs1, input int rs2,
                            output int n_got, output logic [DW-1:0] last_got);
        logic [AW-1:0] exp_q[$];
        logic [PW-1:0] acc;
        logic [PW-1:0] inc;
        logic [PW-1:0] ph;
        int n, q0, d0, start_cyc, j, further, gaps;
        bit stop_eff, timed_out;

        // Reference: address k is the top bits of offset plus the running sum of increments.
        stop_eff = (stop_at >= 1) && ((sc == 16'd0) || (stop_at <= int'(sc)));
        n = stop_eff ? stop_at - 1 : int'(sc);
        acc = '0;
        inc = fw;
        for (int i = 0; i < n; i++) begin
            ph = acc + po;
            exp_q.push_back(ph[PW-1 -: AW]);
            acc = acc + inc;
            if (i + 1 == load_at) inc = load_val;
        end

        q0 = got_q.size();
        d0 = done_n;
        @(posedge clk); #1;
        start        = 1'b1;
        stop         = (stop_at == 0);
        freq_load    = 1'b0;
        freq_word    = fw;
        phase_offset = po;
        sample_count = sc;
        start_cyc    = cyc;
        timed_out    = 1'b1;
        j            = 0;
        while (j < 400) begin
            @(posedge clk); #1;
            j++;
            if (done_n != d0) begin
                timed_out = 1'b0;
                break;
            end
            start        = (j == rs1) || (j == rs2);
            stop         = (j == stop_at);
            freq_load    = (j == load_at);
            freq_word    = freq_load ? load_val : $urandom;
            phase_offset = $urandom;
            sample_count = 16'($urandom);
        end
        start     = 1'b0;
        stop      = 1'b0;
        freq_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check({name, ":timeout"}, 32'(timed_out), 32'd0);
        n_got = got_q.size() - q0;
        check({name, ":count"}, n_got, n);
        for (int i = 0; i < n && i < n_got; i++) begin
            check($sformatf("%s:sample%0d", name, i), got_q[q0+i], DW'(exp_q[i]));
        end
        last_got = '0;
        gaps = 0;
        if (n_got > 0) begin
            last_got = got_q[got_q.size()-1];
            check({name, ":first_valid_cycle"}, got_cyc[q0], start_cyc + RL + 2);
            for (int i = 0; i < n_got; i++) begin
                if (got_cyc[q0+i] != got_cyc[q0] + i) gaps++;
            end
            check({name, ":valid_gaps"}, gaps, 0);
            check({name, ":done_with_last"}, done_at, got_cyc[got_cyc.size()-1]);
        end
        if (n > 0) check({name, ":addr_hold"}, ram_addr, exp_q[n-1]);
        check({name, ":done_pulses"}, done_n - d0, 1);
        check({name, ":busy_after"}, busy, 0);
        check({name, ":ram_we"}, ram_we, 0);
        if (stop_eff) begin
            further = 0;
            for (int i = 0; i < n_got; i++) begin
                if (got_cyc[q0+i] > start_cyc + stop_at) further++;
            end
            check({name, ":after_stop"}, further, (n < 2) ? n : 2);
        end
    endtask

    typedef struct {
        string         name;
        logic [PW-1:0] fw;
        logic [PW-1:0] po;
        logic [15:0]   sc;
        int            n;
        logic [DW-1:0] last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_got, base, d0;
        logic [DW-1:0] last_got;
        logic [PW-1:0] rfw, rpo;
        logic [15:0] rsc;
        int rstop, rload;

        vecs[0] = '{"identity8",  32'h0040_0000, 32'h0000_0000, 16'd8, 8, 16'd7};
        vecs[1] = '{"half_phase", 32'h8000_0000, 32'h4000_0000, 16'd4, 4, 16'd768};
        vecs[2] = '{"dc",         32'h0000_0000, 32'h1234_5678, 16'd5, 5, 16'd72};
        vecs[3] = '{"step2",      32'h0080_0000, 32'h0000_0000, 16'd3, 3, 16'd4};
        vecs[4] = '{"negative",   32'hFFFF_FFFF, 32'h0000_0000, 16'd3, 3, 16'd1023};
        vecs[5] = '{"single",     32'h0000_0001, 32'h0000_0000, 16'd1, 1, 16'd0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; freq_load = 1'b0;
        freq_word = '0; phase_offset = '0; sample_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:ram_addr", ram_addr, 0);
        check("reset:ram_we", ram_we, 0);
        check("reset:wave_out", wave_out, 0);
        check("reset:wave_valid", wave_valid, 0);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        rst = 1'b0;

        // stop while idle is ignored
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        check("idle_stop:busy", busy, 0);

        foreach (vecs[v]) begin
            run_case(vecs[v].name, vecs[v].fw, vecs[v].po, vecs[v].sc, -1, -1, '0, -1, -1,
                     n_got, last_got);
            check({vecs[v].name, ":n"}, n_got, vecs[v].n);
            check({vecs[v].name, ":last"}, last_got, vecs[v].last);
        end

        // frequency reload at address 5: step 1 becomes step 4
        base = got_q.size();
        run_case("freq_load", 32'h0040_0000, '0, 16'd10, -1, 6, 32'h0100_0000, -1, -1,
                 n_got, last_got);
        if (got_q.size() >= base + 9) begin
            check("freq_load:addr7", got_q[base+7], 10);
            check("freq_load:addr8", got_q[base+8], 14);
        end else begin
            check("freq_load:length", got_q.size() - base, 10);
        end

        // continuous run across the table wrap, then stop
        base = got_q.size();
        run_case("cont_wrap", 32'h0080_0000, 32'd1018 << 22, 16'd0, 8, -1, '0, -1, -1,
                 n_got, last_got);
        if (got_q.size() >= base + 4) begin
            check("cont_wrap:pre_wrap", got_q[base+2], 1022);
            check("cont_wrap:post_wrap", got_q[base+3], 0);
        end else begin
            check("cont_wrap:length", got_q.size() - base, 7);
        end

        // start pulses during RUN and during DRAIN change nothing
        run_case("restart_ignored", 32'h0040_0000, 32'h0100_0000, 16'd8, -1, -1, '0, 3, 10,
                 n_got, last_got);
        check("restart_ignored:n", n_got, 8);

        // start and stop together in IDLE: start wins
        run_case("start_stop", 32'h0040_0000, '0, 16'd4, 0, -1, '0, -1, -1, n_got, last_got);

        // asynchronous reset in the middle of a run with reads in flight
        @(posedge clk); #1;
        start = 1'b1; freq_word = 32'h0040_0000; phase_offset = '0; sample_count = 16'd20;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst:ram_addr", ram_addr, 0);
        check("midrst:wave_out", wave_out, 0);
        check("midrst:wave_valid", wave_valid, 0);
        check("midrst:busy", busy, 0);
        check("midrst:done", done, 0);
        base = got_q.size();
        d0 = done_n;
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst:no_valid_after", got_q.size() - base, 0);
        check("midrst:no_done_after", done_n - d0, 0);
        run_case("after_rst", 32'h0040_0000, '0, 16'd8, -1, -1, '0, -1, -1, n_got, last_got);
        check("after_rst:last", last_got, 7);

        for (int r = 0; r < 8; r++) begin
            rfw = $urandom;
            rpo = $urandom;
            rsc = 16'($urandom_range(0, 12));
            rstop = (rsc == 16'd0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 16)) : -1;
            rload = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1;
            run_case($sformatf("rand%0d", r), rfw, rpo, rsc, rstop, rload, $urandom, -1, -1,
                     n_got, last_got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
